// File: rtl/dlatch_input_debouncer_if.sv
// dlatch_input_debouncer_if: pad inputs, enable and conditioned latch-side outputs of the debouncer.
interface dlatch_input_debouncer_if;
  logic ena, d_raw, g_raw;
  logic d_clean, g_clean, d_rise, d_fall, g_rise, g_fall, busy;
  modport master (output ena, d_raw, g_raw, input d_clean, g_clean, d_rise, d_fall, g_rise, g_fall, busy);
  modport slave (input ena, d_raw, g_raw, output d_clean, g_clean, d_rise, d_fall, g_rise, g_fall, busy);
endinterface

// File: rtl/dlatch_input_debouncer.sv
// dlatch_input_debouncer: 2-flop sync + per-channel debounce of D/G pads for the latch.
// `DLATCH_EDGE_PULSE_EN builds the registered rise/fall pulses; otherwise they are tied to 0.
module dlatch_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  dlatch_input_debouncer_if.slave bus
);
  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // channel index 0 is D, 1 is G
  logic [1:0] s1_q, s2_q, clean_q, clean_d, state_q, state_d, mis, acc;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mis[i] = bus.ena && (s2_q[i] != clean_q[i]);
      acc[i] = mis[i] && ((state_q[i] == STABLE) ? (LAST == '0) : (cnt_q[i] == LAST));
      cnt_d[i] = (!mis[i] || acc[i]) ? '0 : (state_q[i] == STABLE) ? ONE : cnt_q[i] + ONE;
      clean_d[i] = acc[i] ? s2_q[i] : clean_q[i];
      state_d[i] = (cnt_d[i] != '0) ? COUNTING : STABLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      clean_q <= '0;
      state_q <= {2{STABLE}};
      cnt_q <= '0;
    end else begin
      s1_q <= {bus.g_raw, bus.d_raw};
      s2_q <= s1_q;
      clean_q <= clean_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.d_clean = clean_q[0];
  assign bus.g_clean = clean_q[1];
  assign bus.busy = (cnt_q[0] != '0) || (cnt_q[1] != '0);
`ifdef DLATCH_EDGE_PULSE_EN
  logic [1:0] rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    rise_d = acc & s2_q;
    fall_d = acc & ~s2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign bus.d_rise = rise_q[0];
  assign bus.d_fall = fall_q[0];
  assign bus.g_rise = rise_q[1];
  assign bus.g_fall = fall_q[1];
`else
  assign bus.d_rise = 1'b0;
  assign bus.d_fall = 1'b0;
  assign bus.g_rise = 1'b0;
  assign bus.g_fall = 1'b0;
`endif
endmodule

// File: tb/tb_dlatch_input_debouncer.sv
// tb_dlatch_input_debouncer: directed scenarios plus random pad activity against a streak-based model.
module tb_dlatch_input_debouncer;
  localparam int DC = 4;
`ifdef DLATCH_EDGE_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  dlatch_input_debouncer_if bus();
  dlatch_input_debouncer #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // model: per channel, a two-sample pad delay and the length of the current enabled mismatch streak
  logic [1:0] ms1, ms2, mclean, mrise, mfall;
  int mrun [2];
  task automatic model_reset();
    ms1 = '0;
    ms2 = '0;
    mclean = '0;
    mrise = '0;
    mfall = '0;
    mrun[0] = 0;
    mrun[1] = 0;
  endtask
  task automatic step();
    logic [1:0] raw;
    raw = {bus.g_raw, bus.d_raw};
    if (!rst_n) model_reset();
    else begin
      for (int c = 0; c < 2; c++) begin
        mrise[c] = 1'b0;
        mfall[c] = 1'b0;
        mrun[c] = (bus.ena && ms2[c] != mclean[c]) ? mrun[c] + 1 : 0;
        if (mrun[c] == DC) begin
          mclean[c] = ms2[c];
          mrise[c] = ms2[c];
          mfall[c] = !ms2[c];
          mrun[c] = 0;
        end
      end
      ms2 = ms1;
      ms1 = raw;
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] obs();
    return {bus.busy, bus.g_fall, bus.g_rise, bus.d_fall, bus.d_rise, bus.g_clean, bus.d_clean};
  endfunction
  function automatic logic [6:0] expv();
    return {mrun[0] != 0 || mrun[1] != 0, PEN & mfall[1], PEN & mrise[1], PEN & mfall[0], PEN & mrise[0],
            mclean[1], mclean[0]};
  endfunction
  task automatic settle(input string name, input logic d, input logic g);
    bus.d_raw = d;
    bus.g_raw = g;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL %s settle: got %b want %b", name, obs(), expv()); end
    end
  endtask
  task automatic test_reset();
    bus.d_raw = 1'b1;
    bus.g_raw = 1'b1;
    bus.ena = 1'b0;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    checks++;
    if (obs() !== 7'b0) begin errors++; $display("FAIL reset_hold: got %b want %b", obs(), 7'b0); end
    rst_n = 1'b1;
    bus.ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL reset_model e%0d: got %b want %b", k, obs(), expv()); end
      checks++;
      if ({bus.g_clean, bus.d_clean} !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL reset_clean e%0d: got %b want %b", k, {bus.g_clean, bus.d_clean}, (k >= 6) ? 2'b11 : 2'b00);
      end
      checks++;
      if ({bus.g_rise, bus.d_rise} !== ((k == 6 && PEN) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL reset_rise e%0d: got %b", k, {bus.g_rise, bus.d_rise});
      end
    end
  endtask
  task automatic test_bounce();
    logic b1, b2;
    settle("bounce", 1'b0, 1'b0);
    b1 = 1'b0;
    b2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.d_raw = (k <= 3);
      step();
      b1 |= bus.busy;
      checks++;
      if (obs() !== expv() || bus.d_clean !== 1'b0) begin
        errors++;
        $display("FAIL bounce_reject e%0d: got %b want %b", k, obs(), expv());
      end
    end
    bus.d_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      b2 |= bus.busy;
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL bounce_model e%0d: got %b want %b", k, obs(), expv()); end
      checks++;
      if (bus.d_clean !== (k >= 6)) begin errors++; $display("FAIL bounce_rise e%0d: got %b want %b", k, bus.d_clean, k >= 6); end
    end
    checks++;
    if ({b1, b2} !== 2'b11) begin errors++; $display("FAIL bounce_busy: got %b want 11", {b1, b2}); end
  endtask
  task automatic test_ena_gating();
    settle("ena", 1'b1, 1'b0);
    bus.g_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.ena = !(k >= 4);
      step();
      checks++;
      if (obs() !== expv() || bus.g_clean !== 1'b0) begin
        errors++;
        $display("FAIL ena_hold e%0d: got %b want %b", k, obs(), expv());
      end
    end
    bus.ena = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL ena_model e%0d: got %b want %b", k, obs(), expv()); end
      checks++;
      if (bus.g_clean !== (k >= 4)) begin errors++; $display("FAIL ena_resume e%0d: got %b want %b", k, bus.g_clean, k >= 4); end
    end
  endtask
  task automatic test_async_reset();
    settle("areset", 1'b0, 1'b1);
    bus.d_raw = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b want 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 7'b0) begin errors++; $display("FAIL areset_immediate: got %b want %b", obs(), 7'b0); end
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL areset_model e%0d: got %b want %b", k, obs(), expv()); end
      checks++;
      if (bus.d_clean !== (k >= 6)) begin errors++; $display("FAIL areset_rise e%0d: got %b want %b", k, bus.d_clean, k >= 6); end
    end
  endtask
  task automatic test_independent();
    settle("indep", 1'b1, 1'b0);
    bus.d_raw = 1'b0;
    bus.g_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL indep_model e%0d: got %b want %b", k, obs(), expv()); end
      checks++;
      if ({bus.g_clean, bus.d_clean} !== ((k >= 6) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL indep_clean e%0d: got %b", k, {bus.g_clean, bus.d_clean});
      end
      checks++;
      if ({bus.g_rise, bus.d_fall, bus.g_fall, bus.d_rise} !== ((k == 6 && PEN) ? 4'b1100 : 4'b0000)) begin
        errors++;
        $display("FAIL indep_pulse e%0d: got %b", k, {bus.g_rise, bus.d_fall, bus.g_fall, bus.d_rise});
      end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) bus.d_raw = !bus.d_raw;
      if ($urandom_range(0, 4) == 0) bus.g_raw = !bus.g_raw;
      bus.ena = ($urandom_range(0, 9) != 0);
      step();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random c%0d: got %b want %b", k, obs(), expv()); end
    end
  endtask
  initial begin
    bus.ena = 1'b0;
    bus.d_raw = 1'b0;
    bus.g_raw = 1'b0;
    model_reset();
    test_reset();
    test_bounce();
    test_ena_gating();
    test_async_reset();
    test_independent();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dlatch_input_debouncer.md
# dlatch_input_debouncer

Input conditioning stage that sits directly upstream of the D-latch user design. Two raw pad inputs (data D and gate G, normally `ui_in[0]` and `ui_in[1]`) are synchronized into the `clk` domain and debounced. Only levels held stable for a programmable number of cycles reach the latch, so switch bounce and metastability never drive latch transparency.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must persist before it is accepted; legal range 1..255.
- `CNT_W`, default 8: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk`.
- `ena`  in  1  design-selected enable (TinyTapeout `ena`).
- `d_raw`  in  1  raw, asynchronous data input.
- `g_raw`  in  1  raw, asynchronous gate input.
- `d_clean`  out  1  debounced data, feeds latch D.
- `g_clean`  out  1  debounced gate, feeds latch enable.
- `d_rise`, `d_fall`  out  1 each  single-cycle edge pulses of `d_clean` (see Configuration).
- `g_rise`, `g_fall`  out  1 each  single-cycle edge pulses of `g_clean`.
- `busy`  out  1  high while either channel's counter is nonzero.

## Operation
- Two identical, independent channels (D, G). Each channel has:
  - a 2-flop synchronizer (`s1` -> `s2`);
  - a `CNT_W`-bit counter;
  - a registered clean output.
- Per-channel FSM, evaluated each edge while `ena`=1:
  - STABLE: counter 0 and `s2`==clean. If `s2`!=clean, move to COUNTING with counter=1.
  - COUNTING: if `s2`==clean (bounce back), counter=0 and return to STABLE.
  - COUNTING: else if counter==DEBOUNCE_CYCLES-1, clean<=`s2`, counter=0, go to STABLE.
  - COUNTING: else counter+1.
  - DEBOUNCE_CYCLES=1 accepts the new value on the first mismatch edge. The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- `ena`=0:
  - synchronizers keep sampling;
  - counters are forced to 0 and FSMs to STABLE;
  - clean outputs hold;
  - all pulses are 0.
  - After `ena` rises, any pending mismatch restarts counting from 1.
- `busy` = (D counter != 0) | (G counter != 0), combinational from registers.
- Reset, asynchronous: `s1`, `s2`, counters, `d_clean`, `g_clean`, all pulses = 0; `busy`=0; FSMs in STABLE. Reset mid-count discards the pending transition.
- Simultaneous D and G transitions are handled independently. The latch sees them change on the same edge only if they mismatch on the same cycles.

## Timing
- Latency: number the first `clk` edge at which `s1` samples the new raw level as edge 1.
  - `s2` holds the new level after edge 2.
  - clean changes at edge 2+DEBOUNCE_CYCLES (edge 6 at the default).
- Rejection: a level that persists in `s2` for fewer than DEBOUNCE_CYCLES consecutive edges never reaches the clean output.
- Pulses are registered and high for exactly the first cycle in which clean shows its new value.
- A raw pulse shorter than one `clk` period may be missed; that is legal.
- All outputs are registered except `busy`.

## Configuration
- Macro `DLATCH_EDGE_PULSE_EN`:
  - Defined: `d_rise`/`d_fall`/`g_rise`/`g_fall` are generated as described.
  - Undefined: the four pulse outputs are tied to 0 and their registers are not built. Clean-path behaviour and timing are identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst_n`=0 with `d_raw`=`g_raw`=1 -> all outputs 0. Release `rst_n`, `ena`=1 -> `d_clean` and `g_clean` rise at edge 6; with macro defined, `d_rise`=`g_rise`=1 for exactly that cycle.
- Bounce: `d_raw` 0->1 for 3 cycles, back to 0 for 2 cycles, then 1 steadily -> `d_clean` stays 0 through the bounce and rises exactly 6 edges after the final 0->1 sample. `busy` is high during both count attempts.
- `ena` gating: start a `g_raw` 0->1 transition, drop `ena` at edge 4 for 5 cycles, then raise it -> `g_clean` stays 0 while `ena`=0. It rises 4 edges after `ena` returns, since `s2` is already 1.
- Async reset mid-count: at edge 4 of a D transition, pulse `rst_n` low between clock edges -> `d_clean`=0 and `busy`=0 immediately. With `d_raw` held 1, `d_clean` rises at edge 6 after reset release.
- Independent channels: `d_raw` 1->0 and `g_raw` 0->1 on the same edge -> `d_fall` and `g_rise` pulse on the same cycle, at edge 6. With the macro undefined, both pulses stay 0 and clean timing is unchanged.
